// File: rtl/intersection_phase_controller.sv
// Round-robin multi-approach intersection sequencer (left turn, green/walk, yellow, all-red)
// with latched pedestrian requests, a tick prescaler and a flashing-red issue mode.
module intersection_phase_controller #(
  parameter int unsigned NUM_APPROACHES = 2,
  parameter int unsigned CNT_W          = 32,
  parameter int unsigned TICK_DIV       = 5000000,
  parameter int unsigned T_LEFT         = 100,
  parameter int unsigned T_GREEN        = 200,
  parameter int unsigned T_WALK         = 100,
  parameter int unsigned T_YELLOW       = 50,
  parameter int unsigned T_ALL_RED      = 20,
  parameter int unsigned FLASH_HALF     = 5,
  localparam int unsigned AW = ($clog2(NUM_APPROACHES) < 1) ? 1 : $clog2(NUM_APPROACHES)
) (
  input  logic                      in_clock,
  input  logic                      in_reset_n,
  input  logic                      in_issue,
  input  logic [NUM_APPROACHES-1:0] in_ped_request,
  input  logic [NUM_APPROACHES-1:0] in_left_enable,
  output logic [NUM_APPROACHES-1:0] out_red,
  output logic [NUM_APPROACHES-1:0] out_yellow,
  output logic [NUM_APPROACHES-1:0] out_green,
  output logic [NUM_APPROACHES-1:0] out_left_turn,
  output logic [NUM_APPROACHES-1:0] out_walk,
  output logic [AW-1:0]             out_active_approach,
  output logic [2:0]                out_phase,
  output logic [CNT_W-1:0]          out_remaining
);

  localparam int unsigned N = NUM_APPROACHES;

  localparam logic [CNT_W-1:0] DivLast   = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] TLeft     = CNT_W'(T_LEFT);
  localparam logic [CNT_W-1:0] TGreen    = CNT_W'(T_GREEN);
  localparam logic [CNT_W-1:0] TYellow   = CNT_W'(T_YELLOW);
  localparam logic [CNT_W-1:0] TAllRed   = CNT_W'(T_ALL_RED);
  localparam logic [CNT_W-1:0] FlashHalf = CNT_W'(FLASH_HALF);
  // Walk shows while the green counter is still above this value.
  localparam logic [CNT_W-1:0] WalkEnd   = CNT_W'(T_GREEN - T_WALK);
  localparam logic [CNT_W-1:0] CntOne    = CNT_W'(1);

  typedef enum logic [2:0] {
    StAllRed = 3'd0,
    StLeft   = 3'd1,
    StGreen  = 3'd2,
    StYellow = 3'd3,
    StIssue  = 3'd4
  } phase_e;

  phase_e           phase_q, phase_d;
  logic [AW-1:0]    app_q, app_d, next_app;
  logic [CNT_W-1:0] cnt_q, cnt_d, pre_q, pre_d;
  logic [N-1:0]     ped_q, ped_d, ped_clr;
  logic             walk_q, walk_d;
  logic             flash_q, flash_d;
  logic             first_q, first_d;
  logic             tick, expire;

  logic [N-1:0]     sel;
  logic [N-1:0]     red_d, yellow_d, green_d, left_d, walk_out_d;
  logic [N-1:0]     red_q, yellow_q, green_q, left_q, walk_out_q;
  logic [CNT_W-1:0] rem_d, rem_q;

  always_comb begin
    tick     = (pre_q == DivLast);
    expire   = tick && (cnt_q == CntOne);
    next_app = (app_q == AW'(N - 1)) ? '0 : app_q + 1'b1;

    phase_d = phase_q;
    app_d   = app_q;
    cnt_d   = cnt_q;
    pre_d   = tick ? '0 : pre_q + 1'b1;
    walk_d  = walk_q;
    flash_d = flash_q;
    first_d = first_q;
    ped_clr = '0;

    if (in_issue) begin
      if (phase_q != StIssue) begin
        phase_d = StIssue;
        cnt_d   = FlashHalf;
        pre_d   = '0;
        flash_d = 1'b1;
        walk_d  = 1'b0;
      end else if (tick) begin
        if (cnt_q == CntOne) begin
          cnt_d   = FlashHalf;
          flash_d = ~flash_q;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
    end else if (phase_q == StIssue) begin
      phase_d = StAllRed;
      cnt_d   = TAllRed;
      pre_d   = '0;
      first_d = 1'b1;
    end else if (expire) begin
      pre_d = '0;
      unique case (phase_q)
        StAllRed: begin
          app_d   = first_q ? '0 : next_app;
          first_d = 1'b0;
          if (in_left_enable[app_d]) begin
            phase_d = StLeft;
            cnt_d   = TLeft;
          end else begin
            phase_d        = StGreen;
            cnt_d          = TGreen;
            walk_d         = ped_q[app_d];
            ped_clr[app_d] = 1'b1;
          end
        end
        StLeft: begin
          phase_d        = StGreen;
          cnt_d          = TGreen;
          walk_d         = ped_q[app_q];
          ped_clr[app_q] = 1'b1;
        end
        StGreen: begin
          phase_d = StYellow;
          cnt_d   = TYellow;
          walk_d  = 1'b0;
        end
        StYellow: begin
          phase_d = StAllRed;
          cnt_d   = TAllRed;
        end
        default: ;
      endcase
    end else if (tick) begin
      cnt_d = cnt_q - 1'b1;
    end

    // A request on the green-entry edge itself stays latched for the next service.
    ped_d = (ped_q & ~ped_clr) | in_ped_request;
  end

  // Lamp decode from next state so lamps change on the same edge as the phase.
  always_comb begin
    sel        = '0;
    sel[app_d] = 1'b1;
    red_d      = '1;
    yellow_d   = '0;
    green_d    = '0;
    left_d     = '0;
    walk_out_d = '0;
    rem_d      = cnt_d;
    unique case (phase_d)
      StLeft: begin
        red_d  = ~sel;
        left_d = sel;
      end
      StGreen: begin
        red_d   = ~sel;
        green_d = sel;
        if (walk_d && (cnt_d > WalkEnd)) walk_out_d = sel;
      end
      StYellow: begin
        red_d    = ~sel;
        yellow_d = sel;
      end
      StIssue: begin
        red_d = flash_d ? '1 : '0;
        rem_d = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge in_clock or negedge in_reset_n) begin
    if (!in_reset_n) begin
      phase_q    <= StAllRed;
      app_q      <= '0;
      cnt_q      <= TAllRed;
      pre_q      <= '0;
      ped_q      <= '0;
      walk_q     <= 1'b0;
      flash_q    <= 1'b0;
      first_q    <= 1'b1;
      red_q      <= '1;
      yellow_q   <= '0;
      green_q    <= '0;
      left_q     <= '0;
      walk_out_q <= '0;
      rem_q      <= TAllRed;
    end else begin
      phase_q    <= phase_d;
      app_q      <= app_d;
      cnt_q      <= cnt_d;
      pre_q      <= pre_d;
      ped_q      <= ped_d;
      walk_q     <= walk_d;
      flash_q    <= flash_d;
      first_q    <= first_d;
      red_q      <= red_d;
      yellow_q   <= yellow_d;
      green_q    <= green_d;
      left_q     <= left_d;
      walk_out_q <= walk_out_d;
      rem_q      <= rem_d;
    end
  end

  assign out_red             = red_q;
  assign out_yellow          = yellow_q;
  assign out_green           = green_q;
  assign out_left_turn       = left_q;
  assign out_walk            = walk_out_q;
  assign out_active_approach = app_q;
  assign out_phase           = phase_q;
  assign out_remaining       = rem_q;

endmodule

// File: tb/tb_intersection_phase_controller.sv
// Randomised scoreboard bench for intersection_phase_controller against a cycle-countdown
// reference model of the phase rules.
module tb_intersection_phase_controller;

  localparam int N   = 2;
  localparam int CW  = 32;
  localparam int TD  = 2;
  localparam int TL  = 3;
  localparam int TG  = 5;
  localparam int TW  = 2;
  localparam int TY  = 2;
  localparam int TAR = 1;
  localparam int FH  = 2;

  localparam int PhAr = 0, PhLt = 1, PhGr = 2, PhYe = 3, PhIs = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           issue;
  logic [N-1:0]   ped, len;
  logic [N-1:0]   red, yellow, green, left_turn, walk;
  logic [0:0]     app;
  logic [2:0]     phase;
  logic [CW-1:0]  remaining;

  typedef struct packed {
    logic [N-1:0]  red;
    logic [N-1:0]  yellow;
    logic [N-1:0]  green;
    logic [N-1:0]  left_turn;
    logic [N-1:0]  walk;
    logic [0:0]    app;
    logic [2:0]    phase;
    logic [CW-1:0] rem;
  } obs_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   passed = 0;

  // Reference model: each phase is a countdown of clock cycles.
  int       m_phase, m_app, m_left, m_elapsed;
  bit       m_first, m_walk;
  bit [N-1:0] m_ped;

  intersection_phase_controller #(
    .NUM_APPROACHES(N), .CNT_W(CW), .TICK_DIV(TD), .T_LEFT(TL), .T_GREEN(TG), .T_WALK(TW),
    .T_YELLOW(TY), .T_ALL_RED(TAR), .FLASH_HALF(FH)
  ) dut (
    .in_clock(clk), .in_reset_n(rst_n), .in_issue(issue), .in_ped_request(ped),
    .in_left_enable(len), .out_red(red), .out_yellow(yellow), .out_green(green),
    .out_left_turn(left_turn), .out_walk(walk), .out_active_approach(app), .out_phase(phase),
    .out_remaining(remaining)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_phase = PhAr; m_app = 0; m_left = TAR * TD; m_elapsed = 0;
    m_first = 1'b1; m_walk = 1'b0; m_ped = '0;
  endtask

  task automatic model_step(input bit r, input bit i, input bit [N-1:0] p, input bit [N-1:0] l);
    bit [N-1:0] clr = '0;
    if (!r) begin
      model_reset();
      return;
    end
    if (i) begin
      if (m_phase != PhIs) begin
        m_phase = PhIs; m_elapsed = 0; m_walk = 1'b0;
      end else begin
        m_elapsed++;
      end
    end else if (m_phase == PhIs) begin
      m_phase = PhAr; m_left = TAR * TD; m_first = 1'b1;
    end else begin
      m_left--;
      if (m_left == 0) begin
        if (m_phase == PhAr) begin
          m_app   = m_first ? 0 : (m_app + 1) % N;
          m_first = 1'b0;
          if (l[m_app]) begin
            m_phase = PhLt; m_left = TL * TD;
          end else begin
            m_phase = PhGr; m_left = TG * TD; m_walk = m_ped[m_app]; clr[m_app] = 1'b1;
          end
        end else if (m_phase == PhLt) begin
          m_phase = PhGr; m_left = TG * TD; m_walk = m_ped[m_app]; clr[m_app] = 1'b1;
        end else if (m_phase == PhGr) begin
          m_phase = PhYe; m_left = TY * TD; m_walk = 1'b0;
        end else begin
          m_phase = PhAr; m_left = TAR * TD;
        end
      end
    end
    m_ped = (m_ped & ~clr) | p;
  endtask

  function automatic obs_t model_out();
    obs_t o;
    bit [N-1:0] sel = '0;
    sel[m_app] = 1'b1;
    o = '0;
    o.red = '1;
    case (m_phase)
      PhLt: begin o.red = ~sel; o.left_turn = sel; end
      PhGr: begin
        o.red = ~sel; o.green = sel;
        if (m_walk && m_left > (TG - TW) * TD) o.walk = sel;
      end
      PhYe: begin o.red = ~sel; o.yellow = sel; end
      PhIs: o.red = (((m_elapsed / (FH * TD)) % 2) == 0) ? '1 : '0;
      default: ;
    endcase
    o.app   = 1'(m_app);
    o.phase = 3'(m_phase);
    o.rem   = (m_phase == PhIs) ? '0 : CW'((m_left + TD - 1) / TD);
    return o;
  endfunction

  task automatic cycle(input logic r, input logic i, input logic [N-1:0] p,
                       input logic [N-1:0] l);
    @(negedge clk);
    rst_n = r; issue = i; ped = p; len = l;
    model_step(r, i, p, l);
    exp_q.push_back(model_out());
  endtask

  function automatic logic [N-1:0] rand_ped();
    return ($urandom_range(0, 11) == 0) ? N'($urandom) : '0;
  endfunction

  // Monitor: every clock the DUT presents one observation.
  always @(posedge clk) begin
    obs_t e, a;
    logic [N-1:0] lit;
    #2;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {red, yellow, green, left_turn, walk, app, phase, remaining};
      checks++;
      if (a === e) passed++;
      else $display("FAIL scoreboard t=%0t got r=%b y=%b g=%b l=%b w=%b app=%0d ph=%0d rem=%0d exp r=%b y=%b g=%b l=%b w=%b app=%0d ph=%0d rem=%0d",
                    $time, a.red, a.yellow, a.green, a.left_turn, a.walk, a.app, a.phase, a.rem,
                    e.red, e.yellow, e.green, e.left_turn, e.walk, e.app, e.phase, e.rem);
      lit = yellow | green | left_turn | walk;
      checks++;
      if ($countones(lit) <= 1 && ((green & yellow) | (green & left_turn) | (yellow & left_turn)) == '0)
        passed++;
      else $display("FAIL safety t=%0t got y=%b g=%b l=%b w=%b required at most one lit head",
                    $time, yellow, green, left_turn, walk);
    end
  end

  initial begin
    logic [N-1:0] l;
    int burst;
    rst_n = 1'b0; issue = 1'b0; ped = '0; len = '1;
    model_reset();
    repeat (3) cycle(1'b0, 1'b0, '0, '1);

    // Normal service with varying left-turn enables.
    l = '1;
    for (int c = 0; c < 300; c++) begin
      if (c > 0 && c % 50 == 0) l = N'($urandom_range(0, 3));
      cycle(1'b1, 1'b0, rand_ped(), l);
    end

    // Random issue bursts from any phase.
    burst = 0;
    for (int c = 0; c < 500; c++) begin
      if (burst == 0 && $urandom_range(0, 59) == 0) burst = $urandom_range(1, 24);
      cycle(1'b1, burst > 0, rand_ped(), N'($urandom));
      if (burst > 0) burst--;
    end

    // Issue raised exactly on a green expiry edge.
    burst = 0;
    for (int c = 0; c < 400; c++) begin
      if (burst == 0 && m_phase == PhGr && m_left == 1) burst = $urandom_range(1, 6);
      cycle(1'b1, burst > 0, rand_ped(), N'($urandom));
      if (burst > 0) burst--;
    end

    // Reset mid-yellow with both pedestrian latches pending.
    cycle(1'b1, 1'b0, '1, '1);
    for (int c = 0; c < 200 && m_phase != PhYe; c++) cycle(1'b1, 1'b0, '0, '1);
    cycle(1'b0, 1'b0, '0, '1);
    #1;
    checks++;
    if (red === '1 && yellow === '0 && green === '0 && left_turn === '0 && walk === '0) passed++;
    else $display("FAIL async_reset got r=%b y=%b g=%b l=%b w=%b required r=11 others 00",
                  red, yellow, green, left_turn, walk);
    cycle(1'b0, 1'b0, '0, '1);
    for (int c = 0; c < 80; c++) cycle(1'b1, 1'b0, '0, 2'b01);
    for (int c = 0; c < 200; c++) cycle(1'b1, $urandom_range(0, 40) == 0, rand_ped(), N'($urandom));

    for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(negedge clk);
    if (exp_q.size() > 0) begin
      checks++;
      $display("FAIL drain got %0d pending observations required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
